// File: rtl/instruction_fetch_decode_if.sv
// ============================================================================
// Module   : instruction_fetch_decode_if
// Brief    : Control, load and decoded-operation bundle for instruction_fetch_decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_decode_if #(
    parameter int WORDSIZE = 64
);
    logic                start;
    logic                instr_load_en;
    logic [4:0]          instr_load_addr;
    logic [31:0]         instr_load_data;
    logic                proc_done;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd_addr;
    logic [WORDSIZE-1:0] rd_in;
    logic [6:0]          op_code;
    logic                issue_valid;
    logic [4:0]          pc;
    logic                halted;
    logic                illegal_op;

    modport master (
        output start, instr_load_en, instr_load_addr, instr_load_data, proc_done,
        input  rs1, rs2, rd_addr, rd_in, op_code, issue_valid, pc, halted, illegal_op
    );

    modport slave (
        input  start, instr_load_en, instr_load_addr, instr_load_data, proc_done,
        output rs1, rs2, rd_addr, rd_in, op_code, issue_valid, pc, halted, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_decode.sv
// ============================================================================
// Module   : instruction_fetch_decode
// Brief    : Sequential fetch/decode/issue engine over a loadable 32-bit imem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_decode #(
    parameter int WORDSIZE   = 64,
    parameter int IMEM_DEPTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    instruction_fetch_decode_if.slave bus
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_ISSUE  = 3'd3;
    localparam logic [2:0] c_WAIT   = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [4:0] c_LAST_PC = 5'(IMEM_DEPTH - 1);

    logic [31:0]         r_imem [0:IMEM_DEPTH-1];
    logic [2:0]          r_state;
    logic [31:0]         r_ir;
    logic [4:0]          r_pc;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rs2;
    logic [4:0]          r_rd_addr;
    logic [WORDSIZE-1:0] r_rd_in;
    logic [6:0]          r_op_code;
    logic                r_issue_valid;
    logic                r_halted;
    logic                r_illegal_op;

    logic [6:0]          w_op;
    logic                w_load_ok;
    logic                w_unused_funct3;

    assign w_op            = r_ir[6:0];
    assign w_unused_funct3 = ^r_ir[14:12];
    assign w_load_ok       = (r_state == c_IDLE) || (r_state == c_HALT);

    // Memory contents survive reset so a program loaded once can be rerun.
    always_ff @(posedge clk) begin
        if (bus.instr_load_en && w_load_ok) begin
            r_imem[bus.instr_load_addr] <= bus.instr_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_ir          <= '0;
            r_pc          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd_addr     <= '0;
            r_rd_in       <= '0;
            r_op_code     <= '0;
            r_issue_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_illegal_op  <= 1'b0;
        end else begin
            r_issue_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_ir    <= r_imem[r_pc];
                    r_state <= c_DECODE;
                end
                c_DECODE: begin
                    if (w_op == 7'd0) begin
                        r_halted <= 1'b1;
                        r_state  <= c_HALT;
                    end else if (w_op > 7'd3) begin
                        r_illegal_op <= 1'b1;
                        r_halted     <= 1'b1;
                        r_state      <= c_HALT;
                    end else begin
                        r_rs1     <= r_ir[19:15];
                        r_rs2     <= r_ir[24:20];
                        r_rd_addr <= r_ir[11:7];
                        r_rd_in   <= {{(WORDSIZE-12){r_ir[31]}}, r_ir[31:20]};
                        r_op_code <= w_op;
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // Pulse lands in the first WAIT cycle, three edges after start.
                    r_issue_valid <= 1'b1;
                    r_state       <= c_WAIT;
                end
                c_WAIT: begin
                    if (bus.proc_done) begin
                        r_op_code <= '0;
                        if (r_pc == c_LAST_PC) begin
                            r_halted <= 1'b1;
                            r_state  <= c_HALT;
                        end else begin
                            r_pc    <= r_pc + 5'd1;
                            r_state <= c_FETCH;
                        end
                    end
                end
                c_HALT: begin
                    r_state <= c_HALT;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.rs1         = r_rs1;
    assign bus.rs2         = r_rs2;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.rd_in       = r_rd_in;
    assign bus.op_code     = r_op_code;
    assign bus.issue_valid = r_issue_valid;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;
    assign bus.illegal_op  = r_illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_decode.sv
// ============================================================================
// Module   : tb_instruction_fetch_decode
// Brief    : Directed self-checking bench for instruction_fetch_decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_decode;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    instruction_fetch_decode_if #(.WORDSIZE(64)) bus ();

    instruction_fetch_decode #(
        .WORDSIZE   (64),
        .IMEM_DEPTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        bus.instr_load_en   = 1'b1;
        bus.instr_load_addr = addr;
        bus.instr_load_data = data;
        tick();
        bus.instr_load_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Cycles after the start edge until issue_valid; 99 if it never comes.
    task automatic wait_issue(output int lat);
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.issue_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int bad_rs1;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start           = 1'b0;
        bus.instr_load_en   = 1'b0;
        bus.instr_load_addr = '0;
        bus.instr_load_data = '0;
        bus.proc_done       = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc",      64'(bus.pc),          64'd0);
        chk("rst_op",      64'(bus.op_code),     64'd0);
        chk("rst_issue",   64'(bus.issue_valid), 64'd0);
        chk("rst_halted",  64'(bus.halted),      64'd0);
        chk("rst_illegal", 64'(bus.illegal_op),  64'd0);
        chk("rst_regs",    64'({bus.rs1, bus.rs2, bus.rd_addr}), 64'd0);
        chk("rst_rd_in",   bus.rd_in,            64'd0);

        // store: rs1=4 rs2=5 imm=5, then op 0 halts
        load(5'd0, 32'h0052_0001);
        load(5'd1, 32'h0000_0000);
        pulse_start();
        wait_issue(lat);
        chk("st_latency", 64'(lat),          64'd3);
        chk("st_op",      64'(bus.op_code),  64'd1);
        chk("st_rs1",     64'(bus.rs1),      64'd4);
        chk("st_rs2",     64'(bus.rs2),      64'd5);
        chk("st_rd",      64'(bus.rd_addr),  64'd0);
        chk("st_rd_in",   bus.rd_in,         64'd5);
        tick();
        chk("st_pulse_once", 64'(bus.issue_valid), 64'd0);
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        chk("st_pc1",     64'(bus.pc),       64'd1);
        chk("st_op_clr",  64'(bus.op_code),  64'd0);
        tick();
        tick();
        chk("st_halted",  64'(bus.halted),   64'd1);
        chk("st_halt_op", 64'(bus.op_code),  64'd0);
        pulse_start();
        tick();
        chk("st_halt_sticky", 64'(bus.halted), 64'd1);
        chk("st_halt_pc",     64'(bus.pc),     64'd1);

        // add: load in HALT is accepted, then rerun from reset
        load(5'd0, 32'h0031_0502);
        do_reset();
        pulse_start();
        wait_issue(lat);
        chk("add_latency", 64'(lat),         64'd3);
        chk("add_op",      64'(bus.op_code), 64'd2);
        chk("add_rs1",     64'(bus.rs1),     64'd2);
        chk("add_rs2",     64'(bus.rs2),     64'd3);
        chk("add_rd",      64'(bus.rd_addr), 64'd10);
        chk("add_rd_in",   bus.rd_in,        64'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("add_hold", 64'({bus.op_code, bus.rs1, bus.rs2, bus.rd_addr}),
                64'({7'd2, 5'd2, 5'd3, 5'd10}));
        end
        chk("add_hold_imm", bus.rd_in, 64'd3);

        // load during WAIT is dropped; reset aborts
        load(5'd0, 32'h0000_0005);
        do_reset();
        chk("wrst_pc",     64'(bus.pc),          64'd0);
        chk("wrst_op",     64'(bus.op_code),     64'd0);
        chk("wrst_halted", 64'(bus.halted),      64'd0);
        tick();
        tick();
        chk("wrst_idle_no_issue", 64'(bus.issue_valid), 64'd0);
        pulse_start();
        wait_issue(lat);
        chk("wrst_readback_lat", 64'(lat),         64'd3);
        chk("wrst_readback_op",  64'(bus.op_code), 64'd2);
        bus.proc_done = 1'b1;
        tick();
        bus.proc_done = 1'b0;
        tick();
        tick();
        chk("wrst_halted_end", 64'(bus.halted), 64'd1);

        // sub with negative immediate
        load(5'd0, 32'hFFF0_0003);
        do_reset();
        pulse_start();
        wait_issue(lat);
        chk("sub_latency", 64'(lat),         64'd3);
        chk("sub_op",      64'(bus.op_code), 64'd3);
        chk("sub_rs2",     64'(bus.rs2),     64'd31);
        chk("sub_rd_in",   bus.rd_in,        64'hFFFF_FFFF_FFFF_FFFF);
        do_reset();

        // illegal opcode halts without issuing
        load(5'd0, 32'h0000_0005);
        pulse_start();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.issue_valid === 1'b1) pulses++;
        end
        chk("ill_no_issue", 64'(pulses),        64'd0);
        chk("ill_flag",     64'(bus.illegal_op), 64'd1);
        chk("ill_halted",   64'(bus.halted),     64'd1);
        chk("ill_op",       64'(bus.op_code),    64'd0);
        pulse_start();
        tick();
        tick();
        chk("ill_start_ignored", 64'({bus.halted, bus.illegal_op, bus.pc}), 64'({1'b1, 1'b1, 5'd0}));
        do_reset();
        chk("ill_rst_clears", 64'({bus.halted, bus.illegal_op}), 64'd0);

        // full program: 32 stores, rs1 tracks the slot index
        for (int i = 0; i < 32; i++) begin
            load(5'(i), 32'h0000_0001 | (32'(i) << 15));
        end
        pulse_start();
        pulses  = 0;
        bad_rs1 = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (bus.halted === 1'b1) break;
            if (bus.issue_valid === 1'b1) begin
                pulses++;
                if (bus.rs1 !== bus.pc) bad_rs1++;
                bus.proc_done = 1'b1;
                tick();
                bus.proc_done = 1'b0;
                if (bus.halted === 1'b1) break;
            end
        end
        chk("seq_pulses",  64'(pulses),      64'd32);
        chk("seq_rs1",     64'(bad_rs1),     64'd0);
        chk("seq_halted",  64'(bus.halted),  64'd1);
        chk("seq_pc",      64'(bus.pc),      64'd31);
        chk("seq_op_clr",  64'(bus.op_code), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_decode.md
INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 Parameter WORDSIZE, default 64, width of rd_in data output.
REQ-002 Parameter IMEM_DEPTH, default 32, instruction memory entries (32-bit each); pc width 5.
REQ-003 Clocking and reset: one clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begins execution from pc=0 when sampled in IDLE.
REQ-007 instr_load_en  input  1  writes instruction memory.
REQ-008 instr_load_addr  input  5  instruction memory write address.
REQ-009 instr_load_data  input  32  instruction word to write.
REQ-010 proc_done  input  1  downstream processor finished current operation.
REQ-011 rs1  output  5  source register 1 address.
REQ-012 rs2  output  5  source register 2 address.
REQ-013 rd_addr  output  5  destination register address.
REQ-014 rd_in  output  WORDSIZE  sign-extended 12-bit immediate.
REQ-015 op_code  output  7  operation for processor (0 none, 1 store, 2 add, 3 sub).
REQ-016 issue_valid  output  1  one-cycle pulse: new operation presented.
REQ-017 pc  output  5  current program counter.
REQ-018 halted  output  1  high in HALT state.
REQ-019 illegal_op  output  1  sticky: op_code field greater than 3 decoded.

Function
REQ-020 Encoding: op=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20], imm=[31:20].
REQ-021 States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT; all outputs registered.
REQ-022 IDLE: start=1 -> FETCH; else stay.
REQ-023 FETCH: instruction register <= imem[pc]; -> DECODE.
REQ-024 DECODE: op=0 -> HALT; op>3 -> illegal_op=1, HALT; else latch rs1, rs2, rd_addr, rd_in, op_code; -> ISSUE.
REQ-025 ISSUE: issue_valid=1 for exactly this one cycle; -> WAIT.
REQ-026 WAIT: rs1, rs2, rd_addr, rd_in, op_code held stable; on proc_done=1: if pc=IMEM_DEPTH-1 -> HALT (pc unchanged), else pc<=pc+1, -> FETCH.
REQ-027 proc_done ignored in all states except WAIT.
REQ-028 op_code=0 in all states except ISSUE and WAIT.
REQ-029 rd_in = {(WORDSIZE-12){imm[11]}, imm}.
REQ-030 Latency: start sampled at edge E0 -> issue_valid high in cycle after edge E0+3.
REQ-031 Instruction memory writes accepted only in IDLE or HALT; ignored otherwise; no reset of memory contents.
REQ-032 Write and start in the same IDLE cycle: write completes; the following FETCH reads the updated word.
REQ-033 HALT is sticky; start ignored; only rst leaves HALT.
REQ-034 pc never wraps; halt occurs at IMEM_DEPTH-1.

Reset
REQ-035 rst=1 at a clock edge: state IDLE, pc=0, op_code=0, issue_valid=0, halted=0, illegal_op=0, rs1=rs2=rd_addr=0, rd_in=0.
REQ-036 Reset mid-operation (any state) aborts immediately; no issue_valid pulse after the reset edge.

Verification
REQ-037 imem[0]=0x00520001, imem[1]=0; start -> issue_valid 3 cycles later, op_code=1, rs1=4, rd_in=5; proc_done -> pc=1 -> halted=1, op_code=0.
REQ-038 imem[0]=0x00310502 -> op_code=2, rs1=2, rs2=3, rd_addr=10, rd_in=3; outputs stable across 5 WAIT cycles until proc_done.
REQ-039 imem[0]=0xFFF00003 -> op_code=3, rd_in=0xFFFFFFFFFFFFFFFF.
REQ-040 imem[0]=0x00000005 -> illegal_op=1, halted=1, issue_valid never asserted; start in HALT has no effect.
REQ-041 All 32 entries op=1 with proc_done after every issue -> 32 issue pulses, halted with pc=31.
REQ-042 rst asserted during WAIT -> next cycle pc=0, op_code=0, state IDLE; load during WAIT ignored (readback via later execution unchanged).
